dcache_sa_top: RTL

//  Parametrised set-associative, write-back, write-allocate data cache between the core's
//  p1 load/store port and the line-wide data memory. Generalises the direct-mapped dcache

---
 rtl/dcache_sa_top.sv | 317 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_sa_top.sv
// Set-associative write-back/write-allocate data cache with pseudo-LRU replacement (optional perf counters: DCACHE_PERF_EN).
// Latency: hits return load data combinationally; a clean miss costs 3 cycles plus memory latency, a dirty victim one extra round trip.
// Backpressure: p1_stall_o holds the core while a miss is serviced; mem_* requests are held stable until mem_ack_i.
module dcache_sa_top #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 32,
    parameter int WAYS   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic              mem_ack_i
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0]       perf_hit_o,
    output logic [31:0]       perf_miss_o,
    output logic [31:0]       perf_wb_o
`endif
);

    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WSEL_W = OFF_W - 2;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS,
        S_WRITEBACK,
        S_REFILL,
        S_REFILL_OK
    } state_t;

    // Request decode
    logic              req;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_wsel;
    logic              unused_addr_lsb;

    assign req             = p1_MemRead_i | p1_MemWrite_i;
    assign req_tag         = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign req_idx         = p1_addr_i[OFF_W +: IDX_W];
    assign req_wsel        = p1_addr_i[2 +: WSEL_W];
    assign unused_addr_lsb = ^p1_addr_i[1:0];

    // Cache storage
    logic [TAG_W-1:0]  tag_q  [WAYS][SETS];
    logic [LINE_W-1:0] line_q [WAYS][SETS];
    logic [SETS-1:0]   valid_q [WAYS];
    logic [SETS-1:0]   dirty_q [WAYS];

    // Control state
    state_t            state_q, state_d;
    logic [TAG_W-1:0]  req_tag_q, req_tag_d;
    logic [IDX_W-1:0]  req_idx_q, req_idx_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_data_q, mem_data_d;

    // Lookup
    logic [WAYS-1:0]   hit_vec;
    logic [WAY_W-1:0]  hit_way;
    logic              hit_any;
    logic              lookup_en;
    logic              hit;
    logic              access_hit;
    logic              store_hit;
    logic              refill_done;
    logic [LINE_W-1:0] hit_line;

    // Victim choice
    logic [WAY_W-1:0]  plru_way;
    logic [WAY_W-1:0]  victim_sel;
    logic              victim_found;
    logic              victim_dirty;

    // Parallel tag compare across all ways; lowest matching way wins (at most one can match)
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
        end
        hit_any = |hit_vec;
    end

    // Lookups are only honoured when no fill is in flight
    assign lookup_en   = (state_q == S_IDLE) || (state_q == S_REFILL_OK);
    assign hit         = lookup_en & hit_any;
    assign access_hit  = req & hit;
    assign store_hit   = p1_MemWrite_i & hit;
    assign refill_done = (state_q == S_REFILL) & mem_ack_i;
    assign p1_stall_o  = req & ~hit;
    assign hit_line    = line_q[hit_way][req_idx];
    assign p1_data_o   = hit_line[32*req_wsel +: 32];

    // Replacement state: one bit per set for 2 ways, 3-bit tree for 4 ways, none for direct-mapped
    if (WAYS == 4) begin : g_lru4
        logic [2:0] lru_q [SETS];
        logic [2:0] lru_upd;

        // Bit 0 picks the victim half, bits 1/2 pick within the left/right pair; touched way becomes MRU
        always_comb begin
            lru_upd    = lru_q[req_idx];
            lru_upd[0] = ~hit_way[1];
            if (hit_way[1]) begin
                lru_upd[2] = ~hit_way[0];
            end else begin
                lru_upd[1] = ~hit_way[0];
            end
        end

        // Tree-PLRU state register, updated on every hit
        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                for (int s = 0; s < SETS; s++) begin
                    lru_q[s] <= '0;
                end
            end else if (access_hit) begin
                lru_q[req_idx] <= lru_upd;
            end
        end

        assign plru_way = lru_q[req_idx_q][0] ? {1'b1, lru_q[req_idx_q][2]}
                                              : {1'b0, lru_q[req_idx_q][1]};
    end else if (WAYS == 2) begin : g_lru2
        logic [SETS-1:0] lru_q;

        // The bit names the least recently used way of the set
        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                lru_q <= '0;
            end else if (access_hit) begin
                lru_q[req_idx] <= ~hit_way[0];
            end
        end

        assign plru_way = lru_q[req_idx_q];
    end else begin : g_lru1
        assign plru_way = '0;
    end

    // Victim: lowest invalid way of the missing set, otherwise the PLRU way
    always_comb begin
        victim_sel   = plru_way;
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid_q[w][req_idx_q]) begin
                victim_sel   = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
        victim_dirty = valid_q[victim_sel][req_idx_q] & dirty_q[victim_sel][req_idx_q];
    end

    // Miss FSM next state and registered memory-port values
    always_comb begin
        state_d    = state_q;
        req_tag_d  = req_tag_q;
        req_idx_d  = req_idx_q;
        victim_d   = victim_q;
        mem_en_d   = mem_en_q;
        mem_wr_d   = mem_wr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        case (state_q)
            S_IDLE: begin
                if (req && !hit) begin
                    state_d   = S_MISS;
                    req_tag_d = req_tag;
                    req_idx_d = req_idx;
                end
            end
            S_MISS: begin
                victim_d = victim_sel;
                mem_en_d = 1'b1;
                if (victim_dirty) begin
                    state_d    = S_WRITEBACK;
                    mem_wr_d   = 1'b1;
                    mem_addr_d = {tag_q[victim_sel][req_idx_q], req_idx_q, {OFF_W{1'b0}}};
                    mem_data_d = line_q[victim_sel][req_idx_q];
                end else begin
                    state_d    = S_REFILL;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
                end
            end
            S_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d    = S_REFILL;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
                end
            end
            S_REFILL: begin
                if (mem_ack_i) begin
                    state_d  = S_REFILL_OK;
                    mem_en_d = 1'b0;
                end
            end
            S_REFILL_OK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                mem_en_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // FSM and memory-port registers; reset abandons any transfer in flight
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            req_tag_q  <= '0;
            req_idx_q  <= '0;
            victim_q   <= '0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            req_tag_q  <= req_tag_d;
            req_idx_q  <= req_idx_d;
            victim_q   <= victim_d;
            mem_en_q   <= mem_en_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Valid/dirty bookkeeping: refill installs a clean line, a store hit marks it dirty
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
        end else begin
            if (refill_done) begin
                valid_q[victim_q][req_idx_q] <= 1'b1;
                dirty_q[victim_q][req_idx_q] <= 1'b0;
            end
            if (store_hit) begin
                dirty_q[hit_way][req_idx] <= 1'b1;
            end
        end
    end

    // Tag and line arrays: no reset needed, valid bits qualify their contents
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (refill_done) begin
                line_q[victim_q][req_idx_q] <= mem_data_i;
                tag_q[victim_q][req_idx_q]  <= req_tag_q;
            end else if (store_hit) begin
                line_q[hit_way][req_idx][32*req_wsel +: 32] <= p1_data_i;
            end
        end
    end

    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_wr_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

`ifdef DCACHE_PERF_EN
    logic [31:0] perf_hit_q, perf_miss_q, perf_wb_q;

    // Event counters, free-running and wrapping
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
            perf_wb_q   <= '0;
        end else begin
            if (access_hit) begin
                perf_hit_q <= perf_hit_q + 32'd1;
            end
            if ((state_q == S_IDLE) && req && !hit) begin
                perf_miss_q <= perf_miss_q + 32'd1;
            end
            if ((state_q == S_WRITEBACK) && mem_ack_i) begin
                perf_wb_q <= perf_wb_q + 32'd1;
            end
        end
    end

    assign perf_hit_o  = perf_hit_q;
    assign perf_miss_o = perf_miss_q;
    assign perf_wb_o   = perf_wb_q;
`endif

endmodule
